// File: rtl/zero_cal_ctrl.sv
// rtl/zero_cal_ctrl.sv - zero-offset calibration sequencer; optional spread check under ZERO_CAL_SPREAD_EN
module zero_cal_ctrl #(
    parameter int          LOG2_N       = 4,
    parameter int          SKIP_N       = 4,
    parameter int          MAX_BAD      = 8,
    parameter int          TIMEOUT_CYC  = 2000000,
    parameter logic [15:0] ZERO_DEFAULT = 16'd0
`ifdef ZERO_CAL_SPREAD_EN
    ,
    parameter logic [15:0] SPREAD_MAX   = 16'd64
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cal_start,
    input  logic [15:0] cal_ref_dist,
    input  logic        zero_wr,
    input  logic [15:0] zero_wr_data,
    input  logic        data_in_valid,
    input  logic [15:0] data_in,
    output logic [15:0] zero_value,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_err,
    output logic [1:0]  err_code
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SKIP  = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_CALC  = 2'd3;

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = $clog2(((SKIP_N > N) ? SKIP_N : N) + 1);
    localparam int BAD_W = $clog2(MAX_BAD + 2);
    localparam int CYC_W = $clog2(TIMEOUT_CYC + 1);
    localparam int ACC_W = 16 + LOG2_N;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BAD_W-1:0] bad_q, bad_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      ref_q, ref_d;
    logic [15:0]      zero_q, zero_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic        busy;
    logic        sample_bad;
    logic        sample_good;
    logic        timeout_hit;
    logic        bad_limit;
    logic        skip_last;
    logic        accum_last;
    logic        calc_fail;
    logic [15:0] avg;

`ifdef ZERO_CAL_SPREAD_EN
    logic [15:0] min_q, min_d;
    logic [15:0] max_q, max_d;
`endif

    assign busy        = (state_q != S_IDLE);
    assign sample_bad  = data_in_valid & ((data_in == 16'hFFFF) | (data_in == 16'h0000));
    assign sample_good = data_in_valid & ~sample_bad;
    assign avg         = acc_q[ACC_W-1:LOG2_N];
    assign timeout_hit = busy && (cyc_q == CYC_W'(TIMEOUT_CYC - 1));
    assign bad_limit   = sample_bad && (bad_q == BAD_W'(MAX_BAD));
    assign skip_last   = (cnt_q == CNT_W'(SKIP_N - 1));
    assign accum_last  = (cnt_q == CNT_W'(N - 1));

    // Run fails in CALC when the mean is below the reference or the samples are too spread out
`ifdef ZERO_CAL_SPREAD_EN
    assign calc_fail = (avg < ref_q) || ((max_q - min_q) > SPREAD_MAX);
`else
    assign calc_fail = (avg < ref_q);
`endif

    // Next-state logic: sequencing, sample filtering, error capture and zero update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        cyc_d   = busy ? cyc_q + CYC_W'(1) : cyc_q;
        acc_d   = acc_q;
        ref_d   = ref_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
`ifdef ZERO_CAL_SPREAD_EN
        min_d   = min_q;
        max_d   = max_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A manual write wins over a start presented in the same cycle
                if (zero_wr) begin
                    zero_d = zero_wr_data;
                end else if (cal_start) begin
                    state_d = (SKIP_N == 0) ? S_ACCUM : S_SKIP;
                    ref_d   = cal_ref_dist;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    cnt_d   = '0;
                    bad_d   = '0;
                    cyc_d   = '0;
                    acc_d   = '0;
`ifdef ZERO_CAL_SPREAD_EN
                    min_d   = 16'hFFFF;
                    max_d   = 16'h0000;
`endif
                end
            end
            S_SKIP: begin
                if (sample_bad) begin
                    bad_d = bad_q + BAD_W'(1);
                end else if (sample_good) begin
                    if (skip_last) begin
                        state_d = S_ACCUM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ACCUM: begin
                if (sample_bad) begin
                    bad_d = bad_q + BAD_W'(1);
                end else if (sample_good) begin
                    acc_d = acc_q + ACC_W'(data_in);
`ifdef ZERO_CAL_SPREAD_EN
                    if (data_in < min_q) min_d = data_in;
                    if (data_in > max_q) max_d = data_in;
`endif
                    if (accum_last) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (calc_fail) begin
                    err_d  = 1'b1;
                    code_d = 2'd3;
                end else begin
                    zero_d = avg - ref_q;
                    done_d = 1'b1;
                end
            end
        endcase

        if (bad_limit && (state_q == S_SKIP || state_q == S_ACCUM)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'd2;
        end

        // Timeout overrides everything, including a CALC that lands on the last cycle
        if (timeout_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'd1;
            zero_d  = zero_q;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bad_q   <= '0;
            cyc_q   <= '0;
            acc_q   <= '0;
            ref_q   <= '0;
            zero_q  <= ZERO_DEFAULT;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
`ifdef ZERO_CAL_SPREAD_EN
            min_q   <= 16'hFFFF;
            max_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            cyc_q   <= cyc_d;
            acc_q   <= acc_d;
            ref_q   <= ref_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
`ifdef ZERO_CAL_SPREAD_EN
            min_q   <= min_d;
            max_q   <= max_d;
`endif
        end
    end

    assign zero_value = zero_q;
    assign cal_busy   = busy;
    assign cal_done   = done_q;
    assign cal_err    = err_q;
    assign err_code   = code_q;

endmodule

// File: tb/tb_zero_cal_ctrl.sv
// tb/tb_zero_cal_ctrl.sv - directed self-checking bench for zero_cal_ctrl
module tb_zero_cal_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cal_start;
    logic [15:0] cal_ref_dist;
    logic        zero_wr;
    logic [15:0] zero_wr_data;
    logic        data_in_valid;
    logic [15:0] data_in;
    logic [15:0] zero_value;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_err;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;
    int n;

    zero_cal_ctrl #(
        .LOG2_N      (4),
        .SKIP_N      (4),
        .MAX_BAD     (8),
        .TIMEOUT_CYC (100),
        .ZERO_DEFAULT(16'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cal_start    (cal_start),
        .cal_ref_dist (cal_ref_dist),
        .zero_wr      (zero_wr),
        .zero_wr_data (zero_wr_data),
        .data_in_valid(data_in_valid),
        .data_in      (data_in),
        .zero_value   (zero_value),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .cal_err      (cal_err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] ref_dist);
        cal_start    = 1'b1;
        cal_ref_dist = ref_dist;
        tick();
        cal_start    = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        data_in_valid = 1'b1;
        data_in       = d;
        tick();
        data_in_valid = 1'b0;
        data_in       = 16'h0;
    endtask

    initial begin
        rst_n = 1'b0; cal_start = 1'b0; cal_ref_dist = 16'd0;
        zero_wr = 1'b0; zero_wr_data = 16'd0; data_in_valid = 1'b0; data_in = 16'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_zero", zero_value, 16'd0);
        check_eq("rst_busy", cal_busy, 1'b0);
        check_eq("rst_done", cal_done, 1'b0);
        check_eq("rst_err",  cal_err,  1'b0);
        check_eq("rst_code", err_code, 2'd0);

        // Nominal: ref 1000, samples 1037 -> zero 37
        start_run(16'd1000);
        check_eq("nom_busy_after_start", cal_busy, 1'b1);
        for (int i = 0; i < 20; i++) send(16'd1037);
        check_eq("nom_busy_calc", cal_busy, 1'b1);
        tick();
        check_eq("nom_done", cal_done, 1'b1);
        check_eq("nom_busy_low", cal_busy, 1'b0);
        check_eq("nom_zero", zero_value, 16'd37);
        check_eq("nom_err", cal_err, 1'b0);
        tick();
        check_eq("nom_done_pulse", cal_done, 1'b0);

        // Five bad samples mixed into the accumulation -> zero 20
        start_run(16'd500);
        for (int i = 0; i < 4; i++) send(16'd520);
        for (int i = 0; i < 21; i++) send((i % 4 == 1) ? 16'hFFFF : 16'd520);
        tick();
        check_eq("bad5_done", cal_done, 1'b1);
        check_eq("bad5_zero", zero_value, 16'd20);

        // Nine bad samples -> error code 2
        start_run(16'd500);
        for (int i = 0; i < 4; i++) send(16'd520);
        for (int i = 0; i < 8; i++) send(16'hFFFF);
        check_eq("bad8_still_busy", cal_busy, 1'b1);
        send(16'hFFFF);
        check_eq("bad9_busy", cal_busy, 1'b0);
        check_eq("bad9_err", cal_err, 1'b1);
        check_eq("bad9_code", err_code, 2'd2);
        check_eq("bad9_done", cal_done, 1'b0);
        check_eq("bad9_zero", zero_value, 16'd20);

        // avg < ref -> error code 3; a new start clears the old error first
        start_run(16'd2000);
        check_eq("lt_err_cleared", cal_err, 1'b0);
        check_eq("lt_code_cleared", err_code, 2'd0);
        for (int i = 0; i < 20; i++) send(16'd1500);
        tick();
        check_eq("lt_err", cal_err, 1'b1);
        check_eq("lt_code", err_code, 2'd3);
        check_eq("lt_done", cal_done, 1'b0);
        check_eq("lt_busy", cal_busy, 1'b0);
        check_eq("lt_zero", zero_value, 16'd20);

        // Timeout with no samples; a start mid-run must not restart it
        start_run(16'd100);
        n = 0;
        while (cal_busy && n < 300) begin
            if (n == 50) begin
                cal_start = 1'b1;
                cal_ref_dist = 16'd7;
            end
            tick();
            cal_start = 1'b0;
            n++;
        end
        check_eq("to_cycles", n, 100);
        check_eq("to_err", cal_err, 1'b1);
        check_eq("to_code", err_code, 2'd1);
        check_eq("to_zero", zero_value, 16'd20);

        // Manual write together with start: write wins, start dropped
        zero_wr = 1'b1; zero_wr_data = 16'h0123; cal_start = 1'b1; cal_ref_dist = 16'd1000;
        tick();
        zero_wr = 1'b0; cal_start = 1'b0;
        check_eq("wr_zero", zero_value, 16'h0123);
        check_eq("wr_start_ignored", cal_busy, 1'b0);

        // Write while busy is ignored; then alternating 1000/1100 samples
        start_run(16'd1000);
        zero_wr = 1'b1; zero_wr_data = 16'h0456;
        tick();
        zero_wr = 1'b0;
        check_eq("wr_busy_ignored", zero_value, 16'h0123);
        for (int i = 0; i < 20; i++) send((i % 2 == 0) ? 16'd1000 : 16'd1100);
        tick();
`ifdef ZERO_CAL_SPREAD_EN
        check_eq("spread_code", err_code, 2'd3);
        check_eq("spread_err", cal_err, 1'b1);
        check_eq("spread_zero", zero_value, 16'h0123);
`else
        check_eq("alt_done", cal_done, 1'b1);
        check_eq("alt_zero", zero_value, 16'd50);
`endif

        // Asynchronous reset in the middle of accumulation
        start_run(16'd1000);
        for (int i = 0; i < 9; i++) send(16'd1200);
        check_eq("mid_busy", cal_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", cal_busy, 1'b0);
        check_eq("arst_zero", zero_value, 16'd0);
        check_eq("arst_err", cal_err, 1'b0);
        check_eq("arst_code", err_code, 2'd0);
        check_eq("arst_done", cal_done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_busy", cal_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
